// File: rtl/flash_stream_pkg.sv
// rtl/flash_stream_pkg.sv - shared state type and lane-width helper for the flash sample streamer
package flash_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    READY,
    DONE
  } state_t;

  // Width of the lane index; a one-lane word still needs a 1-bit index.
  function automatic int lane_idx_w(input int data_w, input int sample_w);
    return (data_w / sample_w > 1) ? $clog2(data_w / sample_w) : 1;
  endfunction

endpackage

// File: rtl/flash_sample_streamer_if.sv
// rtl/flash_sample_streamer_if.sv - Avalon-MM read bus between the streamer and the flash controller
interface flash_sample_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 23
);
  logic [ADDR_W-1:0]   flsh_address;
  logic                flsh_read;
  logic                flsh_waitrequest;
  logic [DATA_W-1:0]   flsh_readdata;
  logic                flsh_readdatavalid;
  logic [DATA_W/8-1:0] flsh_byteenable;

  modport master (
    output flsh_address, flsh_read, flsh_byteenable,
    input  flsh_waitrequest, flsh_readdata, flsh_readdatavalid
  );

  modport slave (
    input  flsh_address, flsh_read, flsh_byteenable,
    output flsh_waitrequest, flsh_readdata, flsh_readdatavalid
  );
endinterface

// File: rtl/flash_word_addr_ctr.sv
// rtl/flash_word_addr_ctr.sv - word address counter with boundary loads, up/down step and wrap
module flash_word_addr_ctr #(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              at_start,
  output logic              at_end,
  output logic              terminal
);

  assign at_start = (addr == START_ADDR);
  assign at_end   = (addr == END_ADDR);
  // Terminal means the next step in the requested direction would wrap.
  assign terminal = down ? at_start : at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= START_ADDR;
    end else if (load_start) begin
      addr <= START_ADDR;
    end else if (load_end) begin
      addr <= END_ADDR;
    end else if (step) begin
      if (down) begin
        addr <= at_start ? END_ADDR : addr - ADDR_W'(1);
      end else begin
        addr <= at_end ? START_ADDR : addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/flash_sample_streamer.sv
// rtl/flash_sample_streamer.sv - fetches flash words and plays them out one sample lane per trigger
module flash_sample_streamer
  import flash_stream_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                SAMPLE_W   = 16,
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = {ADDR_W{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_sample_streamer_if.master flsh,
  input  logic                 startsamplenow,
  input  logic                 dir,
  input  logic                 loop_en,
  input  logic                 restart,
  output logic [SAMPLE_W-1:0]  audio_out,
  output logic                 audio_enable,
  output logic                 done,
  output logic                 underrun
);

  localparam int                N         = DATA_W / SAMPLE_W;
  localparam int                LANE_W    = lane_idx_w(DATA_W, SAMPLE_W);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

  state_t              state, state_n;
  logic                dir_q;
  logic                discard;
  logic [DATA_W-1:0]   word;
  logic [LANE_W-1:0]   lane;
  logic [SAMPLE_W-1:0] lane_sample;
  logic [ADDR_W-1:0]   addr;
  logic                at_start, at_end, terminal, last_lane;
  logic                ctr_load_start, ctr_load_end, ctr_step;
  logic                latch_dir, latch_word, lane_step, emit;
  logic                set_underrun, clr_underrun, set_discard, clr_discard;

  // The counter only steps out of READY, where the freshly sampled dir applies.
  flash_word_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR),
    .END_ADDR  (END_ADDR)
  ) u_addr_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_start(ctr_load_start),
    .load_end  (ctr_load_end),
    .step      (ctr_step),
    .down      (dir),
    .addr      (addr),
    .at_start  (at_start),
    .at_end    (at_end),
    .terminal  (terminal)
  );

  assign flsh.flsh_address    = addr;
  assign flsh.flsh_read       = (state == FETCH);
  assign flsh.flsh_byteenable = '1;
  assign done                 = (state == DONE);
  assign last_lane            = dir_q ? (lane == '0) : (lane == LAST_LANE);

  always_comb begin
    lane_sample = '0;
    for (int k = 0; k < N; k++) begin
      if (lane == LANE_W'(k)) lane_sample = word[k*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    ctr_load_start = 1'b0;
    ctr_load_end   = 1'b0;
    ctr_step       = 1'b0;
    latch_dir      = 1'b0;
    latch_word     = 1'b0;
    lane_step      = 1'b0;
    emit           = 1'b0;
    set_underrun   = 1'b0;
    clr_underrun   = restart;
    set_discard    = 1'b0;
    clr_discard    = 1'b0;
    unique case (state)
      IDLE: begin
        set_underrun = startsamplenow && !restart;
        if (!restart) begin
          latch_dir      = 1'b1;
          ctr_load_start = !dir;
          ctr_load_end   = dir;
          state_n        = FETCH;
        end
      end
      FETCH: begin
        // A restart here must let the request finish; its data is dropped later.
        set_underrun = startsamplenow && !restart;
        set_discard  = restart;
        if (!flsh.flsh_waitrequest) state_n = WAIT;
      end
      WAIT: begin
        set_underrun = startsamplenow && !restart;
        set_discard  = restart;
        if (flsh.flsh_readdatavalid) begin
          if (discard || restart) begin
            clr_discard = 1'b1;
            state_n     = IDLE;
          end else begin
            latch_word = 1'b1;
            state_n    = READY;
          end
        end
      end
      READY: begin
        if (restart) begin
          state_n = IDLE;
        end else if (startsamplenow) begin
          emit = 1'b1;
          if (!last_lane) begin
            lane_step = 1'b1;
          end else if (terminal && !loop_en) begin
            state_n = DONE;
          end else begin
            ctr_step  = 1'b1;
            latch_dir = 1'b1;
            state_n   = FETCH;
          end
        end
      end
      DONE: begin
        if (restart) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q        <= 1'b0;
      discard      <= 1'b0;
      word         <= '0;
      lane         <= '0;
      audio_out    <= '0;
      audio_enable <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      audio_enable <= emit;
      if (emit) audio_out <= lane_sample;
      if (latch_dir) dir_q <= dir;
      if (latch_word) begin
        word <= flsh.flsh_readdata;
        lane <= dir_q ? LAST_LANE : '0;
      end else if (lane_step) begin
        lane <= dir_q ? lane - LANE_W'(1) : lane + LANE_W'(1);
      end
      if (clr_underrun)      underrun <= 1'b0;
      else if (set_underrun) underrun <= 1'b1;
      if (clr_discard)       discard  <= 1'b0;
      else if (set_discard)  discard  <= 1'b1;
    end
  end

endmodule

// File: doc/flash_sample_streamer.md
Name: flash_sample_streamer

Overview:
Parametrised successor to the single-word flash audio reader. It fetches DATA_W-bit words from flash over the Avalon-MM read interface and unpacks each word into DATA_W/SAMPLE_W audio samples, one sample per startsamplenow trigger. It owns its word address, supports forward and reverse playback, and offers loop or one-shot mode. It sits between the flash controller and the audio register, paced by the slow-clock trigger.

Parameters:
DATA_W, 32, flash word width; must be a multiple of SAMPLE_W
SAMPLE_W, 16, audio sample width
ADDR_W, 23, flash word-address width
START_ADDR, 0, first word address of the sample region
END_ADDR, 2**ADDR_W-1, last word address of the region (inclusive); must be >= START_ADDR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
flsh_address  out  ADDR_W  word address of current read
flsh_read  out  1  read request
flsh_waitrequest  in  1  flash stall; request is held while high
flsh_readdata  in  DATA_W  returned word
flsh_readdatavalid  in  1  readdata qualifier
flsh_byteenable  out  DATA_W/8  always all ones
startsamplenow  in  1  one-cycle sample trigger, level-sampled each cycle
dir  in  1  0 = forward, 1 = reverse; sampled only at word fetch
loop_en  in  1  1 = wrap at region end, 0 = stop (one-shot)
restart  in  1  one-cycle pulse; restart playback from the region boundary
audio_out  out  SAMPLE_W  current sample, held between updates
audio_enable  out  1  one-cycle strobe when audio_out updates
done  out  1  high while stopped at region end (one-shot)
underrun  out  1  sticky flag: a trigger arrived with no sample ready; cleared by restart

Behaviour:
- N = DATA_W/SAMPLE_W lanes. Lane k = readdata[k*SAMPLE_W +: SAMPLE_W].
- Reset values: state IDLE, flsh_read 0, flsh_address START_ADDR, audio_out 0, audio_enable 0, done 0, underrun 0, dir_q 0.
- FSM states: IDLE, FETCH, WAIT, READY, DONE.
- IDLE: on the next cycle, latch dir_q = dir, set address to START_ADDR if dir = 0 or END_ADDR if dir = 1, then go to FETCH.
- FETCH: flsh_read = 1 and flsh_address is stable. When flsh_waitrequest is 0 in the same cycle, the request is accepted and the FSM goes to WAIT with flsh_read = 0 on the next cycle. flsh_read is never deasserted while waitrequest is high.
- WAIT: on flsh_readdatavalid, latch the word and set lane = 0 (fwd) or N-1 (rev), then go to READY.
- READY on startsamplenow:
  - Next cycle, audio_out = the lane value and audio_enable = 1 for exactly one cycle.
  - If the lane is not the last lane (N-1 fwd, 0 rev), lane steps by +1 or -1.
  - If the lane is the last lane, the address advances: +1 fwd, -1 rev.
  - At the boundary (END_ADDR fwd, START_ADDR rev): if loop_en, the address wraps to the opposite boundary and the FSM goes to FETCH; if not, the FSM goes to DONE.
  - dir_q re-latches from dir at every FETCH entry. On a direction change, the address is the next address in the new direction from the word just finished.
- Trigger in IDLE, FETCH or WAIT: underrun is set, the sample is dropped, and audio_out/audio_enable are unchanged. A trigger in DONE is ignored and does not set underrun.
- DONE: done = 1. Only restart exits DONE.
- restart in IDLE, READY or DONE: clears done and underrun, goes to IDLE, and takes effect the next cycle.
- restart in FETCH: the pending request completes handshake-legally. Once accepted, the FSM goes to WAIT with a discard flag set.
- restart in WAIT: sets the discard flag. The returning word is dropped, then the FSM goes to IDLE. No bus transaction is ever abandoned.
- restart coincident with startsamplenow: restart wins and no sample is emitted.
- At most one outstanding read at any time. flsh_readdatavalid outside WAIT is ignored.
- Single-word region (START_ADDR = END_ADDR) with loop: the same word is refetched each pass.

Decomposition:
- Package flash_stream_pkg: state enum (IDLE, FETCH, WAIT, READY, DONE) and lane-index width function $clog2(DATA_W/SAMPLE_W).
- One natural sub-module, flash_word_addr_ctr: the address counter with load-start/load-end, inc/dec, boundary detect, wrap and terminal outputs. This replaces the former external inc/dec/rst address controller.

Test Plan:
1. Forward, defaults, readdata = 32'hDEADBEEF, START_ADDR = 0 -> read at addr 0; triggers give audio_out 16'hBEEF then 16'hDEAD, each with a 1-cycle audio_enable; next read is at addr 1.
2. dir = 1, END_ADDR = 7 -> first read at addr 7; samples are 16'hDEAD then 16'hBEEF; next read is at addr 6.
3. waitrequest held high 3 cycles during FETCH -> flsh_read and flsh_address stay stable all 3 cycles; exactly one read is accepted.
4. Trigger while in WAIT -> underrun = 1 and stays set; audio_enable stays 0; the next trigger after readdatavalid outputs 16'hBEEF.
5. START = 0, END = 1: with loop_en = 1, 4 samples are followed by a read at addr 0; with loop_en = 0, done = 1 after the 4th sample and a 5th trigger gives no audio_enable.
6. restart during WAIT, then readdatavalid -> word discarded, no audio_enable, new read at START_ADDR; async rst asserted mid-FETCH -> all outputs return to reset values immediately.
